arp_vlg_tx: RTL and testbench

// Builds and transmits 28-byte ARP payloads (replies and locally initiated requests) to the MAC TX path.

---
 rtl/arp_vlg_tx.sv | 179 +++++++++++++++++
 tb/tb_arp_vlg_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_vlg_tx.sv
// ARP transmit builder: queues one reply and one request job, arbitrates them (reply first),
// and streams the 28-byte ARP payload MSB-first to the MAC after a req/acc handshake.
module arp_vlg_tx #(
  parameter int unsigned ACC_TIMEOUT = 1000,
  parameter int unsigned VERBOSE     = 1,
  parameter string       DUT_STRING  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] dev_mac,
  input  logic [31:0] dev_ipv4,
  input  logic        rx_send,
  input  logic [47:0] rx_src_mac,
  input  logic [31:0] rx_src_ipv4,
  input  logic        req_send,
  input  logic [31:0] req_ipv4,
  output logic        mac_req,
  input  logic        mac_acc,
  output logic [47:0] mac_dst,
  output logic [15:0] mac_ethertype,
  output logic [7:0]  mac_dat,
  output logic        mac_val,
  output logic        mac_sof,
  output logic        mac_eof,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned TW = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LAST  = TW'(ACC_TIMEOUT - 1);
  localparam logic [4:0]    LAST_BYTE = 5'd27;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TX   = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_rep_pend;
  logic            r_req_pend;
  logic [47:0]     r_rep_mac;
  logic [31:0]     r_rep_ipv4;
  logic [31:0]     r_req_ipv4;
  logic            r_sh_rep;
  logic [47:0]     r_sh_mac;
  logic [31:0]     r_sh_ipv4;
  logic [4:0]      r_cnt;
  logic [TW-1:0]   r_tmr;

  logic [223:0]    w_frame;
  logic [4:0]      w_idx_nxt;
  logic [7:0]      w_sh;
  logic [7:0]      w_byte_nxt;
  logic            w_take_rep;
  logic            w_take_req;
  logic            w_unused_cfg;

  // Simulation-only knobs have no hardware meaning.
  assign w_unused_cfg  = (VERBOSE != 0) ^ (DUT_STRING == "");
  assign mac_ethertype = 16'h0806;

  assign w_take_rep = (r_state == S_IDLE) & r_rep_pend;
  assign w_take_req = (r_state == S_IDLE) & ~r_rep_pend & r_req_pend;

  // Payload image of the frame in flight; byte 0 sits in the top bits.
  always_comb begin
    w_frame = {16'h0001, 16'h0800, 8'h06, 8'h04,
               (r_sh_rep ? 16'h0002 : 16'h0001),
               dev_mac, dev_ipv4,
               (r_sh_rep ? r_sh_mac : 48'h0),
               r_sh_ipv4};
    w_idx_nxt = (r_state == S_TX) ? (r_cnt + 5'd1) : 5'd0;
    w_sh      = '0;
    if (w_idx_nxt <= LAST_BYTE) begin
      w_sh = 8'(LAST_BYTE - w_idx_nxt) << 3;
    end
    w_byte_nxt = w_frame[w_sh +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rep_pend <= 1'b0;
      r_req_pend <= 1'b0;
      r_rep_mac  <= '0;
      r_rep_ipv4 <= '0;
      r_req_ipv4 <= '0;
      r_sh_rep   <= 1'b0;
      r_sh_mac   <= '0;
      r_sh_ipv4  <= '0;
      r_cnt      <= '0;
      r_tmr      <= '0;
      mac_req    <= 1'b0;
      mac_dst    <= '0;
      mac_dat    <= '0;
      mac_val    <= 1'b0;
      mac_sof    <= 1'b0;
      mac_eof    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // A fresh pulse re-arms its slot even in the cycle the old job is taken.
      r_rep_pend <= rx_send  | (r_rep_pend & ~w_take_rep);
      r_req_pend <= req_send | (r_req_pend & ~w_take_req);
      if (rx_send) begin
        r_rep_mac  <= rx_src_mac;
        r_rep_ipv4 <= rx_src_ipv4;
      end
      if (req_send) begin
        r_req_ipv4 <= req_ipv4;
      end

      case (r_state)
        S_IDLE: begin
          if (r_rep_pend | r_req_pend) begin
            r_state  <= S_WAIT;
            mac_req  <= 1'b1;
            busy     <= 1'b1;
            r_tmr    <= '0;
            r_sh_rep <= r_rep_pend;
            if (r_rep_pend) begin
              r_sh_mac  <= r_rep_mac;
              r_sh_ipv4 <= r_rep_ipv4;
              mac_dst   <= r_rep_mac;
            end else begin
              r_sh_mac  <= '0;
              r_sh_ipv4 <= r_req_ipv4;
              mac_dst   <= '1;
            end
          end
        end
        S_WAIT: begin
          if (mac_acc) begin
            r_state <= S_TX;
            mac_req <= 1'b0;
            r_cnt   <= '0;
            mac_val <= 1'b1;
            mac_sof <= 1'b1;
            mac_eof <= 1'b0;
            mac_dat <= w_byte_nxt;
          end else if (r_tmr == TMR_LAST) begin
            r_state <= S_IDLE;
            mac_req <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_TX: begin
          if (r_cnt == LAST_BYTE) begin
            r_state <= S_IDLE;
            mac_val <= 1'b0;
            mac_sof <= 1'b0;
            mac_eof <= 1'b0;
            mac_dat <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt   <= w_idx_nxt;
            mac_dat <= w_byte_nxt;
            mac_sof <= 1'b0;
            mac_eof <= (w_idx_nxt == LAST_BYTE);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_vlg_tx.sv
// Directed bench for arp_vlg_tx: expected payload bytes are queued at stimulus time
// and popped by a monitor as the DUT streams them.
module tb_arp_vlg_tx;

  typedef struct {
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic [47:0] dst;
  } exp_t;

  localparam logic [47:0] DEV_MAC = 48'h02_00_00_00_00_AA;
  localparam logic [31:0] DEV_IP  = 32'hC0A8010A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] dev_mac = DEV_MAC;
  logic [31:0] dev_ipv4 = DEV_IP;
  logic        rx_send = 1'b0;
  logic [47:0] rx_src_mac = '0;
  logic [31:0] rx_src_ipv4 = '0;
  logic        req_send = 1'b0;
  logic [31:0] req_ipv4 = '0;
  logic        mac_req;
  logic        mac_acc;
  logic [47:0] mac_dst;
  logic [15:0] mac_ethertype;
  logic [7:0]  mac_dat;
  logic        mac_val, mac_sof, mac_eof, busy, done, err;
  logic        acc_en = 1'b1;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  bit   in_frame = 1'b0;
  exp_t q[$];

  arp_vlg_tx #(.ACC_TIMEOUT(16), .VERBOSE(0), .DUT_STRING("tb")) dut (
    .clk(clk), .rst(rst), .dev_mac(dev_mac), .dev_ipv4(dev_ipv4),
    .rx_send(rx_send), .rx_src_mac(rx_src_mac), .rx_src_ipv4(rx_src_ipv4),
    .req_send(req_send), .req_ipv4(req_ipv4),
    .mac_req(mac_req), .mac_acc(mac_acc), .mac_dst(mac_dst), .mac_ethertype(mac_ethertype),
    .mac_dat(mac_dat), .mac_val(mac_val), .mac_sof(mac_sof), .mac_eof(mac_eof),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // MAC model: grants immediately whenever enabled.
  assign mac_acc = acc_en & mac_req;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input bit rep, input logic [47:0] tmac, input logic [31:0] tip);
    logic [7:0]  p[28];
    logic [47:0] dm;
    logic [31:0] di;
    exp_t        e;
    dm = DEV_MAC;
    di = DEV_IP;
    p[0] = 8'h00; p[1] = 8'h01; p[2] = 8'h08; p[3] = 8'h00;
    p[4] = 8'h06; p[5] = 8'h04; p[6] = 8'h00; p[7] = rep ? 8'h02 : 8'h01;
    for (int i = 0; i < 6; i++) p[8+i]  = dm[47-8*i -: 8];
    for (int i = 0; i < 4; i++) p[14+i] = di[31-8*i -: 8];
    for (int i = 0; i < 6; i++) p[18+i] = rep ? tmac[47-8*i -: 8] : 8'h00;
    for (int i = 0; i < 4; i++) p[24+i] = tip[31-8*i -: 8];
    for (int i = 0; i < 28; i++) begin
      e.d   = p[i];
      e.sof = (i == 0);
      e.eof = (i == 27);
      e.dst = rep ? tmac : 48'hFFFF_FFFF_FFFF;
      q.push_back(e);
    end
  endtask

  // One-cycle pulses on either source; slot inputs are scrambled afterwards.
  task automatic pulse(input bit rx, input bit rq, input logic [47:0] smac,
                       input logic [31:0] sip, input logic [31:0] rip);
    @(posedge clk); #1;
    rx_send = rx; rx_src_mac = smac; rx_src_ipv4 = sip;
    req_send = rq; req_ipv4 = rip;
    @(posedge clk); #1;
    rx_send = 1'b0; req_send = 1'b0;
    rx_src_mac = 48'hDEAD_BEEF_0000; rx_src_ipv4 = 32'hDEADBEEF; req_ipv4 = 32'hBADC0FFE;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < bound);
    chk("done_pulse", 64'(done), 64'(1));
  endtask

  task automatic wait_sof(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mac_sof && n < bound);
    chk("sof_seen", 64'(mac_sof), 64'(1));
  endtask

  // Scoreboard monitor: every valid byte must match the head of the queue; no gaps mid-frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (in_frame) chk("no_gap", 64'(mac_val), 64'(1));
      if (mac_val) begin
        chk("val_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("dat", 64'(mac_dat), 64'(e.d));
          chk("sof", 64'(mac_sof), 64'(e.sof));
          chk("eof", 64'(mac_eof), 64'(e.eof));
          chk("dst", 64'(mac_dst), 64'(e.dst));
        end
      end
      in_frame = mac_val && !mac_eof;
    end
  end

  initial begin
    int d0;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(mac_req), 64'(0));
    chk("rst_val", 64'(mac_val), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dst", 64'(mac_dst), 64'(0));
    chk("rst_dat", 64'(mac_dat), 64'(0));
    chk("ethertype", 64'(mac_ethertype), 64'(16'h0806));
    rst = 1'b0;

    // 1: reply, with request latency
    push_frame(1'b1, 48'h02_00_00_00_00_01, 32'hC0A80102);
    pulse(1'b1, 1'b0, 48'h02_00_00_00_00_01, 32'hC0A80102, 32'h0);
    @(negedge clk);
    chk("lat_req_lo", 64'(mac_req), 64'(0));
    @(negedge clk);
    chk("lat_req_hi", 64'(mac_req), 64'(1));
    chk("busy_hi", 64'(busy), 64'(1));
    @(negedge clk);
    chk("sof_after_acc", 64'(mac_sof), 64'(1));
    wait_done(60);
    @(negedge clk);
    chk("done_1cyc", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("t1_drained", 64'(q.size()), 64'(0));

    // 2: request
    push_frame(1'b0, 48'h0, 32'h0A000005);
    pulse(1'b0, 1'b1, 48'h0, 32'h0, 32'h0A000005);
    wait_done(60);
    @(negedge clk);
    chk("t2_drained", 64'(q.size()), 64'(0));

    // 3: simultaneous reply and request, reply first and back-to-back
    d0 = done_cnt;
    push_frame(1'b1, 48'h02_00_00_00_00_07, 32'hC0A80107);
    push_frame(1'b0, 48'h0, 32'h0A000009);
    pulse(1'b1, 1'b1, 48'h02_00_00_00_00_07, 32'hC0A80107, 32'h0A000009);
    wait_done(60);
    @(negedge clk);
    chk("b2b_req", 64'(mac_req), 64'(1));
    wait_done(60);
    @(negedge clk);
    chk("two_dones", 64'(done_cnt - d0), 64'(2));
    chk("t3_drained", 64'(q.size()), 64'(0));

    // 4: acc timeout
    acc_en = 1'b0;
    pulse(1'b1, 1'b0, 48'h02_00_00_00_00_09, 32'hC0A80109, 32'h0);
    n = 0;
    while (!mac_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (mac_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_cycles", 64'(n), 64'(16));
    chk("err_pulse", 64'(err), 64'(1));
    chk("to_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("err_1cyc", 64'(err), 64'(0));
    acc_en = 1'b1;
    repeat (3) @(negedge clk);

    // 5: overwrite of reply slot during TX
    push_frame(1'b1, 48'h02_00_00_00_00_01, 32'hC0A80102);
    pulse(1'b1, 1'b0, 48'h02_00_00_00_00_01, 32'hC0A80102, 32'h0);
    wait_sof(20);
    push_frame(1'b1, 48'h02_00_00_00_00_03, 32'hC0A80103);
    pulse(1'b1, 1'b0, 48'h02_00_00_00_00_03, 32'hC0A80103, 32'h0);
    wait_done(60);
    wait_done(60);
    @(negedge clk);
    chk("t5_drained", 64'(q.size()), 64'(0));

    // 6: async reset at byte 10 with a request still pending
    push_frame(1'b1, 48'h02_00_00_00_00_05, 32'hC0A80105);
    pulse(1'b1, 1'b1, 48'h02_00_00_00_00_05, 32'hC0A80105, 32'h0A000001);
    wait_sof(20);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_val", 64'(mac_val), 64'(0));
    chk("arst_eof", 64'(mac_eof), 64'(0));
    chk("arst_dat", 64'(mac_dat), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_req", 64'(mac_req), 64'(0));
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (mac_req || busy) n++;
    end
    chk("no_pending_after_rst", 64'(n), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
